dual_port_memory: RTL and testbench

Parametrised single-clock memory with one write port and one registered read port, generalising the team's 32×4 RAM. It adds:
- configurable width and depth;
- a selectable read-during-write policy;
- a read-valid strobe;
- a post-reset clear sweep that zeroes every location before accepting traffic.

It sits in the processor datapath as the data/register store.

---
 rtl/dual_port_memory_pkg.sv | 13 +
 rtl/dual_port_memory_if.sv | 26 ++
 rtl/dual_port_memory.sv | 119 +++++++++++
 tb/tb_dual_port_memory.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_memory_pkg.sv
// Shared definitions for the datapath store: read-during-write policy codes
// and the controller state encoding.
package dual_port_memory_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/dual_port_memory_if.sv
// Request/response bundle of the memory: one write port, one registered read
// port, plus status strobes.
interface dual_port_memory_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] data_to_write;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  read_valid;
    logic                  ready;
    logic                  addr_error;

    modport master (
        output read, write, read_address, write_address, data_to_write,
        input  data_read, read_valid, ready, addr_error
    );

    modport slave (
        input  read, write, read_address, write_address, data_to_write,
        output data_read, read_valid, ready, addr_error
    );
endinterface

// File: rtl/dual_port_memory.sv
// Single-clock memory with one write port, one registered read port, a
// selectable read-during-write policy and a post-reset zeroing sweep.
module dual_port_memory
    import dual_port_memory_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 2 ** ADDR_WIDTH,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    dual_port_memory_if.slave   bus
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic                  RESET_READY = (CLEAR_ON_RESET == 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
    logic                  read_valid_q, read_valid_d;
    logic                  ready_q, ready_d;
    logic                  addr_error_q, addr_error_d;

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Widen by one bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign rd_in_range = {1'b0, bus.read_address}  < DEPTH_L;
    assign wr_in_range = {1'b0, bus.write_address} < DEPTH_L;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        data_read_d  = data_read_q;
        read_valid_d = 1'b0;
        ready_d      = ready_q;
        addr_error_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = bus.write_address;
        mem_wdata    = bus.data_to_write;
        rd_word      = '0;
        if (rd_in_range) begin
            rd_word = mem_q[bus.read_address];
        end

        case (state_q)
            CLEAR: begin
                // The sweep owns the write port; user requests are ignored.
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = RUN;
                    ready_d   = 1'b1;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                mem_we = bus.write && wr_in_range;
                if (bus.read) begin
                    read_valid_d = 1'b1;
                    data_read_d  = rd_word;
                    // rd_word is the pre-edge contents, which is read-first by nature.
                    if (RDW_MODE == RDW_WRITE_FIRST && mem_we &&
                        bus.write_address == bus.read_address) begin
                        data_read_d = bus.data_to_write;
                    end
                end
                addr_error_d = (bus.read && !rd_in_range) || (bus.write && !wr_in_range);
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= '0;
            data_read_q  <= '0;
            read_valid_q <= 1'b0;
            ready_q      <= RESET_READY;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            data_read_q  <= data_read_d;
            read_valid_q <= read_valid_d;
            ready_q      <= ready_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign bus.data_read  = data_read_q;
    assign bus.read_valid = read_valid_q;
    assign bus.ready      = ready_q;
    assign bus.addr_error = addr_error_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: read-first and write-first 32-word instances
// driven in lockstep, plus a 20-word instance for out-of-range addressing.
module tb_dual_port_memory;
    import dual_port_memory_pkg::*;

    localparam int DW = 4;
    localparam int AW = 5;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            ev;
        logic [DW-1:0] eda;
        logic [DW-1:0] edb;
        bit            eerr;
    } vec_t;

    typedef struct {
        bit            ev;
        logic [DW-1:0] eda;
        logic [DW-1:0] edb;
        bit            eerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    dual_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    dual_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();
    dual_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32),
                       .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32),
                       .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(20),
                       .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    function automatic vec_t mk(input bit rd, input bit wr, input int ra, input int wa,
                                input int wd, input bit ev, input int eda, input int edb,
                                input bit eerr);
        vec_t v;
        v.rd = rd;  v.wr = wr;
        v.ra = AW'(ra);  v.wa = AW'(wa);  v.wd = DW'(wd);
        v.ev = ev;  v.eda = DW'(eda);  v.edb = DW'(edb);  v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic drive_ab(input bit rd, input bit wr, input logic [AW-1:0] ra,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        ifa.read = rd;  ifa.write = wr;  ifa.read_address = ra;
        ifa.write_address = wa;  ifa.data_to_write = wd;
        ifb.read = rd;  ifb.write = wr;  ifb.read_address = ra;
        ifb.write_address = wa;  ifb.data_to_write = wd;
    endtask

    task automatic drive_c(input bit rd, input bit wr, input logic [AW-1:0] ra,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        ifc.read = rd;  ifc.write = wr;  ifc.read_address = ra;
        ifc.write_address = wa;  ifc.data_to_write = wd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.ev = v.ev;  e.eda = v.eda;  e.edb = v.edb;  e.eerr = v.eerr;
        sb.push_back(e);
    endtask

    // Called at posedge+1: drive one request, compare after the next edge.
    task automatic step_ab(input vec_t v, input string name);
        exp_t e;
        drive_ab(v.rd, v.wr, v.ra, v.wa, v.wd);
        push_exp(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({name, " read_valid_a"}, 32'(ifa.read_valid), 32'(e.ev));
        chk({name, " read_valid_b"}, 32'(ifb.read_valid), 32'(e.ev));
        chk({name, " data_read_a"},  32'(ifa.data_read),  32'(e.eda));
        chk({name, " data_read_b"},  32'(ifb.data_read),  32'(e.edb));
        chk({name, " addr_error_a"}, 32'(ifa.addr_error), 32'(e.eerr));
        chk({name, " addr_error_b"}, 32'(ifb.addr_error), 32'(e.eerr));
    endtask

    task automatic step_c(input vec_t v, input string name);
        exp_t e;
        drive_c(v.rd, v.wr, v.ra, v.wa, v.wd);
        push_exp(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({name, " read_valid_c"}, 32'(ifc.read_valid), 32'(e.ev));
        chk({name, " data_read_c"},  32'(ifc.data_read),  32'(e.eda));
        chk({name, " addr_error_c"}, 32'(ifc.addr_error), 32'(e.eerr));
    endtask

    // Counts edges after rst release until ready; any request strobe seen
    // from the 32-word instances while sweeping is an error.
    task automatic wait_ready(input string name);
        int na = -1;
        int nc = -1;
        int strobes = 0;
        int ab_diff = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            if (ifa.read_valid || ifa.addr_error || ifb.read_valid || ifb.addr_error) strobes++;
            if (ifa.ready !== ifb.ready) ab_diff++;
            if (ifc.ready && nc < 0) nc = cyc;
            if (ifa.ready && na < 0) begin
                na = cyc;
                drive_ab(1'b0, 1'b0, '0, '0, '0);
            end
            if (na >= 0 && nc >= 0) break;
        end
        chk({name, " ready_cycles_32"}, 32'(na), 32'd32);
        chk({name, " ready_cycles_20"}, 32'(nc), 32'd20);
        chk({name, " strobes_in_clear"}, 32'(strobes), 32'd0);
        chk({name, " ready_a_vs_b"}, 32'(ab_diff), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(0, 1,  0,  3, 'hA, 0, 'h0, 'h0, 0);
        tbl[1]  = mk(1, 0,  3,  0, 'h0, 1, 'hA, 'hA, 0);
        tbl[2]  = mk(0, 0,  0,  0, 'h0, 0, 'hA, 'hA, 0);
        tbl[3]  = mk(0, 1,  0,  7, 'h5, 0, 'hA, 'hA, 0);
        tbl[4]  = mk(1, 1,  7,  7, 'hC, 1, 'h5, 'hC, 0);
        tbl[5]  = mk(1, 0,  7,  0, 'h0, 1, 'hC, 'hC, 0);
        tbl[6]  = mk(1, 1,  3,  9, 'h3, 1, 'hA, 'hA, 0);
        tbl[7]  = mk(1, 0,  9,  0, 'h0, 1, 'h3, 'h3, 0);
        tbl[8]  = mk(1, 1, 31, 31, 'hF, 1, 'h0, 'hF, 0);
        tbl[9]  = mk(1, 0, 31,  0, 'h0, 1, 'hF, 'hF, 0);
        tbl[10] = mk(1, 0,  0,  0, 'h0, 1, 'h0, 'h0, 0);
        tbl[11] = mk(0, 0,  0,  0, 'h0, 0, 'h0, 'h0, 0);

        rst = 1'b1;
        drive_ab(1'b0, 1'b0, '0, '0, '0);
        drive_c(1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset data_read_a",  32'(ifa.data_read),  32'd0);
        chk("reset read_valid_a", 32'(ifa.read_valid), 32'd0);
        chk("reset addr_error_a", 32'(ifa.addr_error), 32'd0);
        chk("reset ready_a",      32'(ifa.ready),      32'd0);
        chk("reset ready_c",      32'(ifc.ready),      32'd0);

        // Requests held during the sweep must be ignored.
        drive_ab(1'b1, 1'b1, '0, '0, 4'h9);
        rst = 1'b0;
        wait_ready("clear");

        for (int a = 0; a < 32; a++) step_ab(mk(1, 0, a, 0, 0, 1, 0, 0, 0), $sformatf("sweep_rd%0d", a));

        for (int i = 0; i < 12; i++) step_ab(tbl[i], $sformatf("tbl%0d", i));

        step_c(mk(0, 1,  0, 19, 'h6, 0, 'h0, 0, 0), "c_wr19");
        step_c(mk(1, 0, 19,  0, 'h0, 1, 'h6, 0, 0), "c_rd19");
        step_c(mk(1, 1, 25, 25, 'hF, 1, 'h0, 0, 1), "c_oor25");
        step_c(mk(0, 0,  0,  0, 'h0, 0, 'h0, 0, 0), "c_err_clears");
        step_c(mk(0, 1,  0, 20, 'hF, 0, 'h0, 0, 1), "c_wr20");
        step_c(mk(1, 1, 20, 31, 'hF, 1, 'h0, 0, 1), "c_both_oor");
        for (int a = 0; a < 20; a++)
            step_c(mk(1, 0, a, 0, 0, 1, (a == 19) ? 'h6 : 'h0, 0, 0), $sformatf("c_rd%0d", a));
        drive_c(1'b0, 1'b0, '0, '0, '0);

        step_ab(mk(0, 1, 0, 15, 'hF, 0, 'h0, 'h0, 0), "pre_wr15");
        step_ab(mk(1, 0, 15, 0, 'h0, 1, 'hF, 'hF, 0), "pre_rd15");
        drive_ab(1'b0, 1'b0, '0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst data_read_a",  32'(ifa.data_read),  32'd0);
        chk("async_rst read_valid_a", 32'(ifa.read_valid), 32'd0);
        chk("async_rst ready_a",      32'(ifa.ready),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midsweep ready_a", 32'(ifa.ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("resweep");
        step_ab(mk(0, 0, 0, 0, 0, 0, 'h0, 'h0, 0), "post_idle");
        step_ab(mk(1, 0, 15, 0, 0, 1, 'h0, 'h0, 0), "post_rd15");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
